wb_stage_buf: RTL and testbench



---
 rtl/wb_stage_buf.sv | 219 +++++++++++++++++++++
 tb/tb_wb_stage_buf.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_buf.sv
// wb_stage_buf -- writeback-stage buffer between MEM and the GRF/CP0 write port.
//
// Payload crosses on a valid/ready handshake. DEPTH=1 is a plain register with
// a combinational ready path. DEPTH=2 is a skid buffer with a registered ready
// and FIFO order. Writeback controls are decoded from the head instruction.
// DATA_W must be at least 32, because the decode reads instr[31:0].
//
// Optional feature macro: WB_RETIRE_CNT_EN adds retire_cnt[CNT_W-1:0]. It counts
// consumed entries that do not carry an exception, wraps, and ignores flush.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   in_valid / in_ready           MEM-side handshake
//   in_pc..in_epc, in_exc         payload fields and the exception flag
//   flush                         drop all held entries and any same-cycle input
//   out_valid / out_ready         GRF/CP0-side handshake
//   out_pc..out_epc               head payload (holds its value while invalid)
//   out_we, out_waddr, out_wd_sel GRF write controls (wd_sel: 0 ao, 1 rd, 2 pc+8, 3 cp0)
//   out_cp0_we, out_cp0_addr      mtc0 write enable and register number
//   out_eret                      head is eret
module wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_ao,
  input  logic [DATA_W-1:0] in_out,
  input  logic [DATA_W-1:0] in_epc,
  input  logic              in_exc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_ao,
  output logic [DATA_W-1:0] out_out,
  output logic [DATA_W-1:0] out_epc,
  output logic              out_we,
  output logic [4:0]        out_waddr,
  output logic [2:0]        out_wd_sel,
  output logic              out_cp0_we,
  output logic [4:0]        out_cp0_addr,
  output logic              out_eret
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] ao;
    logic [DATA_W-1:0] out;
    logic [DATA_W-1:0] epc;
    logic              exc;
  } entry_t;

  entry_t in_ent;
  entry_t head_p0;
  entry_t tail_p1;
  logic   vld_p0, vld_p1;
  logic   vld_p0_nxt, vld_p1_nxt;
  logic   rdy_q, rdy_nxt;
  logic   acc, pop;
  logic   ld_head_in, ld_head_tail, ld_tail_in;

  assign in_ent = '{pc: in_pc, instr: in_instr, rd: in_rd, ao: in_ao,
                    out: in_out, epc: in_epc, exc: in_exc};

  // rdy_q is 0 in reset and during the first edge after release. For DEPTH=2
  // it is the whole ready. For DEPTH=1 it only qualifies the combinational path.
  if (DEPTH == 1) begin : g_depth1
    assign in_ready = rdy_q & (~vld_p0 | out_ready);
  end else begin : g_depth2
    assign in_ready = rdy_q;
  end

  assign out_valid = vld_p0;
  assign acc       = in_valid & in_ready & ~flush;
  assign pop       = vld_p0 & out_ready & ~flush;

  // Occupancy and steering. While full, in_ready is 0, so a pop from a full
  // buffer never coincides with an accept.
  always_comb begin
    vld_p0_nxt   = vld_p0;
    vld_p1_nxt   = vld_p1;
    ld_head_in   = 1'b0;
    ld_head_tail = 1'b0;
    ld_tail_in   = 1'b0;
    if (flush) begin
      vld_p0_nxt = 1'b0;
      vld_p1_nxt = 1'b0;
    end else if (pop && vld_p1) begin
      ld_head_tail = 1'b1;
      vld_p1_nxt   = 1'b0;
    end else if (pop) begin
      if (acc) ld_head_in = 1'b1;
      else     vld_p0_nxt = 1'b0;
    end else if (acc) begin
      if (!vld_p0) begin
        ld_head_in = 1'b1;
        vld_p0_nxt = 1'b1;
      end else if (DEPTH > 1) begin
        ld_tail_in = 1'b1;
        vld_p1_nxt = 1'b1;
      end
    end
    rdy_nxt = (DEPTH == 1) ? 1'b1 : ~(vld_p0_nxt & vld_p1_nxt);
  end

  // ---- stage p0: head entry, control ----
  // Payload is reset as well, so the outputs read zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      rdy_q   <= 1'b0;
      head_p0 <= '0;
    end else begin
      vld_p0 <= vld_p0_nxt;
      vld_p1 <= vld_p1_nxt;
      rdy_q  <= rdy_nxt;
      if (ld_head_in)        head_p0 <= in_ent;
      else if (ld_head_tail) head_p0 <= tail_p1;
    end
  end

  // ---- stage p1: skid entry ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tail_p1 <= '0;
    end else if (ld_tail_in) begin
      tail_p1 <= in_ent;
    end
  end

  assign out_pc    = head_p0.pc;
  assign out_instr = head_p0.instr;
  assign out_rd    = head_p0.rd;
  assign out_ao    = head_p0.ao;
  assign out_out   = head_p0.out;
  assign out_epc   = head_p0.epc;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rdf;
  logic [4:0] dec_waddr;
  logic [2:0] dec_sel;
  logic       dec_cp0;

  assign op    = head_p0.instr[31:26];
  assign rs    = head_p0.instr[25:21];
  assign rt    = head_p0.instr[20:16];
  assign rdf   = head_p0.instr[15:11];
  assign funct = head_p0.instr[5:0];

  always_comb begin
    dec_waddr = 5'd0;
    dec_sel   = 3'd0;
    dec_cp0   = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          // jr, mthi, mtlo, mult, multu, div, divu have no GRF destination
          6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: dec_waddr = 5'd0;
          default:                                         dec_waddr = rdf;
        endcase
        if (funct == 6'h09) dec_sel = 3'd2;
      end
      6'h03: begin
        dec_waddr = 5'd31;
        dec_sel   = 3'd2;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec_waddr = rt;
        dec_sel   = 3'd1;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: dec_waddr = rt;
      6'h10: begin
        if (rs == 5'd0) begin
          dec_waddr = rt;
          dec_sel   = 3'd3;
        end else if (rs == 5'd4) begin
          dec_cp0 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_waddr    = dec_waddr;
  assign out_wd_sel   = dec_sel;
  assign out_cp0_addr = rdf;
  assign out_we       = vld_p0 & ~head_p0.exc & (dec_waddr != 5'd0);
  // mtc0 never has a GRF destination, so the zero-destination gate can only
  // apply to the GRF write. Applying it here would block every mtc0.
  assign out_cp0_we   = vld_p0 & ~head_p0.exc & dec_cp0;
  assign out_eret     = vld_p0 & (head_p0.instr[31:0] == 32'h4200_0018);

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt <= '0;
    end else if (pop && !head_p0.exc) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
module tb_wb_stage_buf;

  typedef struct packed {
    logic [31:0] pc, instr, rd, ao, out, epc;
    logic        exc, we;
    logic [4:0]  waddr;
    logic [2:0]  wd_sel;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic        eret;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT a: DEPTH=2
  logic        a_valid, a_ready, a_exc, a_flush, a_ovalid, a_oready;
  logic [31:0] a_pc, a_instr, a_rd, a_ao, a_out, a_epc;
  logic [31:0] a_opc, a_oinstr, a_ord, a_oao, a_oout, a_oepc;
  logic        a_we, a_cp0_we, a_eret;
  logic [4:0]  a_waddr, a_cp0_addr;
  logic [2:0]  a_wd_sel;
  // DUT b: DEPTH=1, CNT_W=4
  logic        b_valid, b_ready, b_exc, b_flush, b_ovalid, b_oready;
  logic [31:0] b_pc, b_instr, b_rd, b_ao, b_out, b_epc;
  logic [31:0] b_opc, b_oinstr, b_ord, b_oao, b_oout, b_oepc;
  logic        b_we, b_cp0_we, b_eret;
  logic [4:0]  b_waddr, b_cp0_addr;
  logic [2:0]  b_wd_sel;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] a_retire_cnt;
  logic [3:0]  b_retire_cnt;
`endif

  wb_stage_buf #(.DATA_W(32), .DEPTH(2), .CNT_W(32)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_pc(a_pc), .in_instr(a_instr), .in_rd(a_rd), .in_ao(a_ao), .in_out(a_out),
    .in_epc(a_epc), .in_exc(a_exc), .flush(a_flush), .out_valid(a_ovalid),
    .out_ready(a_oready), .out_pc(a_opc), .out_instr(a_oinstr), .out_rd(a_ord),
    .out_ao(a_oao), .out_out(a_oout), .out_epc(a_oepc), .out_we(a_we),
    .out_waddr(a_waddr), .out_wd_sel(a_wd_sel), .out_cp0_we(a_cp0_we),
    .out_cp0_addr(a_cp0_addr), .out_eret(a_eret)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(a_retire_cnt)
`endif
  );

  wb_stage_buf #(.DATA_W(32), .DEPTH(1), .CNT_W(4)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_pc(b_pc), .in_instr(b_instr), .in_rd(b_rd), .in_ao(b_ao), .in_out(b_out),
    .in_epc(b_epc), .in_exc(b_exc), .flush(b_flush), .out_valid(b_ovalid),
    .out_ready(b_oready), .out_pc(b_opc), .out_instr(b_oinstr), .out_rd(b_ord),
    .out_ao(b_oao), .out_out(b_oout), .out_epc(b_oepc), .out_we(b_we),
    .out_waddr(b_waddr), .out_wd_sel(b_wd_sel), .out_cp0_we(b_cp0_we),
    .out_cp0_addr(b_cp0_addr), .out_eret(b_eret)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(b_retire_cnt)
`endif
  );

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t hold_a = '0;
  exp_t hold_b = '0;
  logic m_rdy_en = 1'b0;
  logic [3:0] m_cnt = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic exc, input logic we, input logic [4:0] wa,
                              input logic [2:0] sel, input logic cw, input logic er);
    exp_t e;
    e.pc = pc; e.instr = instr; e.rd = pc ^ 32'h1111_0000; e.ao = pc + 32'h40;
    e.out = ~pc; e.epc = pc - 32'd4; e.exc = exc; e.we = we; e.waddr = wa;
    e.wd_sel = sel; e.cp0_we = cw; e.cp0_addr = instr[15:11]; e.eret = er;
    return e;
  endfunction

  task automatic cycle_a(input logic v, input exp_t e, input logic ordy, input logic fl);
    logic acc, pop;
    a_valid = v; a_pc = e.pc; a_instr = e.instr; a_rd = e.rd; a_ao = e.ao;
    a_out = e.out; a_epc = e.epc; a_exc = e.exc; a_flush = fl; a_oready = ordy;
    @(negedge clk);
    chk("a_in_ready", a_ready, m_rdy_en && sb_a.size() < 2);
    chk("a_out_valid", a_ovalid, sb_a.size() != 0);
    if (sb_a.size() != 0) begin
      hold_a = sb_a[0];
      chk("a_pc", a_opc, sb_a[0].pc);         chk("a_instr", a_oinstr, sb_a[0].instr);
      chk("a_rd", a_ord, sb_a[0].rd);         chk("a_ao", a_oao, sb_a[0].ao);
      chk("a_out", a_oout, sb_a[0].out);      chk("a_epc", a_oepc, sb_a[0].epc);
      chk("a_we", a_we, sb_a[0].we);          chk("a_waddr", a_waddr, sb_a[0].waddr);
      chk("a_wd_sel", a_wd_sel, sb_a[0].wd_sel);
      chk("a_cp0_we", a_cp0_we, sb_a[0].cp0_we);
      chk("a_cp0_addr", a_cp0_addr, sb_a[0].cp0_addr);
      chk("a_eret", a_eret, sb_a[0].eret);
    end else begin
      chk("a_hold_pc", a_opc, hold_a.pc);     chk("a_hold_instr", a_oinstr, hold_a.instr);
      chk("a_idle_we", a_we, 0);              chk("a_idle_eret", a_eret, 0);
    end
    acc = v && m_rdy_en && sb_a.size() < 2 && !fl;
    pop = sb_a.size() != 0 && ordy && !fl;
    @(posedge clk);
    if (fl) sb_a.delete();
    else begin
      if (pop) void'(sb_a.pop_front());
      if (acc) sb_a.push_back(e);
    end
    m_rdy_en = 1'b1;
    #1;
  endtask

  task automatic cycle_b(input logic v, input exp_t e, input logic ordy, input logic fl);
    logic acc, pop;
    b_valid = v; b_pc = e.pc; b_instr = e.instr; b_rd = e.rd; b_ao = e.ao;
    b_out = e.out; b_epc = e.epc; b_exc = e.exc; b_flush = fl; b_oready = ordy;
    @(negedge clk);
    chk("b_in_ready", b_ready, m_rdy_en && (sb_b.size() == 0 || ordy));
    chk("b_out_valid", b_ovalid, sb_b.size() != 0);
    if (sb_b.size() != 0) begin
      hold_b = sb_b[0];
      chk("b_pc", b_opc, sb_b[0].pc);         chk("b_instr", b_oinstr, sb_b[0].instr);
      chk("b_we", b_we, sb_b[0].we);          chk("b_waddr", b_waddr, sb_b[0].waddr);
    end else begin
      chk("b_hold_pc", b_opc, hold_b.pc);
    end
`ifdef WB_RETIRE_CNT_EN
    chk("b_retire_cnt", b_retire_cnt, m_cnt);
`endif
    acc = v && m_rdy_en && (sb_b.size() == 0 || ordy) && !fl;
    pop = sb_b.size() != 0 && ordy && !fl;
    @(posedge clk);
    if (fl) sb_b.delete();
    else begin
      if (pop) begin
        if (!sb_b[0].exc) m_cnt = m_cnt + 4'd1;
        void'(sb_b.pop_front());
      end
      if (acc) sb_b.push_back(e);
    end
    m_rdy_en = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("rel_a_in_ready", a_ready, 0);
    chk("rel_b_in_ready", b_ready, 0);
    @(posedge clk);
    m_rdy_en = 1'b1;
    #1;
  endtask

  exp_t nop;

  initial begin
    nop = mk(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    a_valid = 0; a_pc = 0; a_instr = 0; a_rd = 0; a_ao = 0; a_out = 0; a_epc = 0;
    a_exc = 0; a_flush = 0; a_oready = 0;
    b_valid = 0; b_pc = 0; b_instr = 0; b_rd = 0; b_ao = 0; b_out = 0; b_epc = 0;
    b_exc = 0; b_flush = 0; b_oready = 0;

    // reset state
    @(posedge clk); #2;
    chk("rst_out_valid", a_ovalid, 0);
    chk("rst_in_ready", a_ready, 0);
    chk("rst_out_pc", a_opc, 0);
    chk("rst_out_epc", a_oepc, 0);
    chk("rst_b_out_valid", b_ovalid, 0);
    release_reset();

    // streaming: addu $3 then lw $5
    cycle_a(1, mk(32'h0040_0000, 32'h0022_1821, 0, 1, 5'd3, 3'd0, 0, 0), 1, 0);
    cycle_a(1, mk(32'h0040_0004, 32'h8C05_0004, 0, 1, 5'd5, 3'd1, 0, 0), 1, 0);
    cycle_a(0, nop, 1, 0);
    cycle_a(0, nop, 1, 0);

    // decode and gating
    cycle_a(1, mk(32'h0040_0100, 32'h3400_0001, 0, 0, 5'd0,  3'd0, 0, 0), 1, 0); // ori $0
    cycle_a(1, mk(32'h0040_0104, 32'h4084_6000, 1, 0, 5'd0,  3'd0, 0, 0), 1, 0); // mtc0, exc
    cycle_a(1, mk(32'h0040_0108, 32'h4084_6000, 0, 0, 5'd0,  3'd0, 1, 0), 1, 0); // mtc0
    cycle_a(1, mk(32'h0040_010C, 32'h4200_0018, 0, 0, 5'd0,  3'd0, 0, 1), 1, 0); // eret
    cycle_a(1, mk(32'h0040_0110, 32'h0C00_0010, 0, 1, 5'd31, 3'd2, 0, 0), 1, 0); // jal
    cycle_a(1, mk(32'h0040_0114, 32'h4008_6000, 0, 1, 5'd8,  3'd3, 0, 0), 1, 0); // mfc0 $8
    cycle_a(1, mk(32'h0040_0118, 32'h03E0_0008, 0, 0, 5'd0,  3'd0, 0, 0), 1, 0); // jr
    cycle_a(1, mk(32'h0040_011C, 32'h0020_F809, 0, 1, 5'd31, 3'd2, 0, 0), 1, 0); // jalr
    cycle_a(1, mk(32'h0040_0120, 32'h0043_2018, 0, 0, 5'd0,  3'd0, 0, 0), 1, 0); // mult
    cycle_a(1, mk(32'h0040_0124, 32'h8C05_0004, 1, 0, 5'd5,  3'd1, 0, 0), 1, 0); // lw, exc
    cycle_a(0, nop, 1, 0);
    cycle_a(0, nop, 1, 0);

    // backpressure: three offered, two held, third waits at the source
    cycle_a(1, mk(32'h0000_1000, 32'h0022_1821, 0, 1, 5'd3, 3'd0, 0, 0), 0, 0);
    cycle_a(1, mk(32'h0000_2000, 32'h0022_2021, 0, 1, 5'd4, 3'd0, 0, 0), 0, 0);
    cycle_a(1, mk(32'h0000_3000, 32'h0022_2821, 0, 1, 5'd5, 3'd0, 0, 0), 0, 0);
    cycle_a(1, mk(32'h0000_3000, 32'h0022_2821, 0, 1, 5'd5, 3'd0, 0, 0), 0, 0);
    cycle_a(1, mk(32'h0000_3000, 32'h0022_2821, 0, 1, 5'd5, 3'd0, 0, 0), 1, 0);
    cycle_a(1, mk(32'h0000_3000, 32'h0022_2821, 0, 1, 5'd5, 3'd0, 0, 0), 1, 0);
    cycle_a(0, nop, 1, 0);
    cycle_a(0, nop, 1, 0);

    // flush a full buffer with a valid input
    cycle_a(1, mk(32'h0000_4000, 32'h0022_1821, 0, 1, 5'd3, 3'd0, 0, 0), 0, 0);
    cycle_a(1, mk(32'h0000_5000, 32'h0022_1821, 0, 1, 5'd3, 3'd0, 0, 0), 0, 0);
    cycle_a(1, mk(32'h0000_6000, 32'h0022_1821, 0, 1, 5'd3, 3'd0, 0, 0), 1, 1);
    cycle_a(0, nop, 1, 0);
    cycle_a(1, mk(32'h0000_7000, 32'h8C05_0004, 0, 1, 5'd5, 3'd1, 0, 0), 1, 0);
    cycle_a(0, nop, 1, 0);

    // asynchronous reset with two entries held
    cycle_a(1, mk(32'h0000_8000, 32'h0022_1821, 0, 1, 5'd3, 3'd0, 0, 0), 0, 0);
    cycle_a(1, mk(32'h0000_9000, 32'h0022_1821, 0, 1, 5'd3, 3'd0, 0, 0), 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", a_ovalid, 0);
    chk("arst_out_pc", a_opc, 0);
    chk("arst_out_instr", a_oinstr, 0);
    chk("arst_out_we", a_we, 0);
    chk("arst_in_ready", a_ready, 0);
    sb_a.delete(); sb_b.delete(); hold_a = '0; hold_b = '0; m_rdy_en = 1'b0; m_cnt = 4'd0;
    a_valid = 0;
    release_reset();
    cycle_a(0, nop, 1, 0);

    // DEPTH=1: 17 clean consumes, then one with an exception
    for (int i = 0; i < 17; i++)
      cycle_b(1, mk(32'h0001_0000 + 32'(i * 4), 32'h0022_1821, 0, 1, 5'd3, 3'd0, 0, 0), 1, 0);
    cycle_b(0, nop, 1, 0);
`ifdef WB_RETIRE_CNT_EN
    chk("b_retire_wrap", b_retire_cnt, 4'd1);
`endif
    cycle_b(1, mk(32'h0002_0000, 32'h0022_1821, 1, 0, 5'd3, 3'd0, 0, 0), 1, 0);
    cycle_b(0, nop, 1, 0);
    // in_ready follows out_ready while full
    cycle_b(1, mk(32'h0003_0000, 32'h8C05_0004, 0, 1, 5'd5, 3'd1, 0, 0), 0, 0);
    cycle_b(1, mk(32'h0003_1000, 32'h8C05_0004, 0, 1, 5'd5, 3'd1, 0, 0), 0, 0);
    cycle_b(1, mk(32'h0003_1000, 32'h8C05_0004, 0, 1, 5'd5, 3'd1, 0, 0), 1, 0);
    cycle_b(0, nop, 0, 0);
    cycle_b(1, mk(32'h0003_2000, 32'h8C05_0004, 0, 1, 5'd5, 3'd1, 0, 0), 1, 1);
    cycle_b(0, nop, 1, 0);
    cycle_b(0, nop, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
